// File: rtl/psum_write_arbiter.sv
// Round-robin arbiter sharing the psum buffer write port among NUM_PE pipe controllers,
// with a one-cycle registered write stage, flush/drain handshake and a write counter.
module psum_write_arbiter #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ID_W   = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [NUM_PE-1:0]        req,
    input  logic [NUM_PE*DATA_W-1:0] psum_in,
    input  logic                     buf_full,
    input  logic                     flush,
    input  logic                     count_clear,
    output logic [NUM_PE-1:0]        grant,
    output logic                     buf_wen,
    output logic [DATA_W-1:0]        buf_wdata,
    output logic [ID_W-1:0]          buf_src,
    output logic                     flush_done,
    output logic                     busy,
    output logic [15:0]              write_count
);

    localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              gnt_ok;
    int unsigned       scan_idx;
    logic [DATA_W-1:0] psum_arr [NUM_PE];

    for (genvar i = 0; i < NUM_PE; i++) begin : g_unpack
        assign psum_arr[i] = psum_in[i*DATA_W +: DATA_W];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_PE.
    always_comb begin
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = 0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            scan_idx = 32'(rr_ptr) + i;
            if (scan_idx >= NUM_PE) begin
                scan_idx = scan_idx - NUM_PE;
            end
            if (!gnt_any && req[IDX_W'(scan_idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(scan_idx);
            end
        end
    end

    // rstn gates the grant so requests are ignored while reset is held.
    assign gnt_ok = rstn & en & (state == RUN) & ~flush & ~buf_full & gnt_any;

    always_comb begin
        grant = '0;
        if (gnt_ok) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign busy = (|req) | buf_wen | (state != RUN);

    always_comb begin
        next_state = state;
        if (en) begin
            case (state)
                RUN:     if (flush) next_state = DRAIN;
                DRAIN:   if (!buf_wen) next_state = DONE;
                DONE:    next_state = RUN;
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            state      <= next_state;
            flush_done <= (next_state == DONE);
        end
    end

    // Pointer and one-deep write stage; data/source hold when no grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            buf_wen   <= 1'b0;
            buf_wdata <= '0;
            buf_src   <= '0;
        end else begin
            buf_wen <= gnt_ok;
            if (gnt_ok) begin
                rr_ptr    <= (gnt_idx == IDX_W'(NUM_PE - 1)) ? '0 : gnt_idx + 1'b1;
                buf_wdata <= psum_arr[gnt_idx];
                buf_src   <= ID_W'(gnt_idx);
            end
        end
    end

    // Clear wins over a coincident write; the write itself is unaffected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_count <= '0;
        end else if (count_clear) begin
            write_count <= '0;
        end else if (buf_wen) begin
            write_count <= write_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_psum_write_arbiter.sv
// Scenario bench for psum_write_arbiter: a reference model queues expected writes
// at each granted edge and a monitor pops and compares them on the buffer port.
module tb_psum_write_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rstn, en, buf_full, flush, count_clear;
    logic [NP-1:0]     req;
    logic [NP*DW-1:0]  psum_in;
    logic [NP-1:0]     grant;
    logic              buf_wen;
    logic [DW-1:0]     buf_wdata;
    logic [IW-1:0]     buf_src;
    logic              flush_done;
    logic              busy;
    logic [15:0]       write_count;

    typedef struct packed {
        logic [IW-1:0] src;
        logic [DW-1:0] data;
    } wr_t;

    wr_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [1:0] m_ptr;
    int   m_state;
    logic m_wen;

    psum_write_arbiter #(.NUM_PE(NP), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .req(req), .psum_in(psum_in),
        .buf_full(buf_full), .flush(flush), .count_clear(count_clear),
        .grant(grant), .buf_wen(buf_wen), .buf_wdata(buf_wdata), .buf_src(buf_src),
        .flush_done(flush_done), .busy(busy), .write_count(write_count)
    );

    always #5 clk = ~clk;

    function automatic int model_pick();
        int j;
        if (!(rstn && en && m_state == 0 && !flush && !buf_full)) return -1;
        for (int i = 0; i < NP; i++) begin
            j = int'(m_ptr) + i;
            if (j >= NP) j = j - NP;
            if (req[j[1:0]]) return j;
        end
        return -1;
    endfunction

    // Reference model: pushes the expected write at every granted edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ptr   = 2'd0;
            m_state = 0;
            m_wen   = 1'b0;
            sb.delete();
        end else begin
            int  g;
            wr_t w;
            g = model_pick();
            if (en) begin
                case (m_state)
                    0: if (flush) m_state = 1;
                    1: if (!m_wen) m_state = 2;
                    2: m_state = 0;
                    default: m_state = 0;
                endcase
            end
            m_wen = (g >= 0);
            if (g >= 0) begin
                w.src  = g[1:0];
                w.data = psum_in[g*DW +: DW];
                sb.push_back(w);
                m_ptr = 2'(g + 1);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        n_tests++;
        if (buf_wen !== (sb.size() > 0)) begin
            n_fail++;
            $display("FAIL sb_wen: buf_wen=%0b expected %0b at %0t", buf_wen, sb.size() > 0, $time);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (buf_src !== e.src || buf_wdata !== e.data) begin
                n_fail++;
                $display("FAIL sb_data: src=%0d data=%h expected src=%0d data=%h", buf_src, buf_wdata, e.src, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        #1;
        n_tests++;
        if (grant !== 4'b0 || buf_wen !== 1'b0 || buf_wdata !== 16'h0 || buf_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outs: grant=%b wen=%b wdata=%h src=%0d expected 0,0,0,0", grant, buf_wen, buf_wdata, buf_src);
        end
        n_tests++;
        if (write_count !== 16'd0 || flush_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: count=%0d fdone=%b busy=%b expected 0,0,0", write_count, flush_done, busy);
        end
        req = 4'hF;
        #1;
        n_tests++;
        if (grant !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_grant: grant=%b expected 0000", grant);
        end
        req = 4'h0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_round_robin();
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_tests++;
            if (grant !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_grant k=%0d: grant=%b expected %b", k, grant, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                n_tests++;
                if (buf_wen !== 1'b1 || buf_src !== 2'((k - 1) % 4) || buf_wdata !== 16'(16'h0100 + (k - 1) % 4)) begin
                    n_fail++;
                    $display("FAIL rr_write k=%0d: wen=%b src=%0d data=%h expected 1,%0d,%h",
                             k, buf_wen, buf_src, buf_wdata, (k - 1) % 4, 16'(16'h0100 + (k - 1) % 4));
                end
            end
            tick();
        end
        req = 4'h0;
        #1;
        n_tests++;
        if (buf_wen !== 1'b1 || buf_src !== 2'd3 || buf_wdata !== 16'h0103) begin
            n_fail++;
            $display("FAIL rr_last: wen=%b src=%0d data=%h expected 1,3,0103", buf_wen, buf_src, buf_wdata);
        end
        tick();
        #1;
        n_tests++;
        if (write_count !== 16'd8 || buf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_count: count=%0d wen=%b expected 8,0", write_count, buf_wen);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        #1;
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b expected 0100", grant);
        end
        tick();
        req = 4'b0101;
        #1;
        n_tests++;
        if (buf_wen !== 1'b1 || buf_src !== 2'd2) begin
            n_fail++;
            $display("FAIL single_write: wen=%b src=%0d expected 1,2", buf_wen, buf_src);
        end
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_wrap: grant=%b expected 0001", grant);
        end
        tick();
        req = 4'b0100;
        #1;
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_next: grant=%b expected 0100", grant);
        end
        tick();
        req = 4'b0000;
        #1;
        n_tests++;
        if (buf_wen !== 1'b1 || buf_src !== 2'd2) begin
            n_fail++;
            $display("FAIL single_write2: wen=%b src=%0d expected 1,2", buf_wen, buf_src);
        end
        tick();
    endtask

    task automatic test_buf_full();
        en  = 1'b0;
        req = 4'b0010;
        #1;
        n_tests++;
        if (grant !== 4'b0) begin
            n_fail++;
            $display("FAIL en_low: grant=%b expected 0000", grant);
        end
        tick();
        en       = 1'b1;
        buf_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (grant !== 4'b0 || buf_wen !== 1'b0) begin
                n_fail++;
                $display("FAIL full_block k=%0d: grant=%b wen=%b expected 0000,0", k, grant, buf_wen);
            end
            tick();
        end
        buf_full = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL full_release: grant=%b expected 0010", grant);
        end
        tick();
        req = 4'b0000;
        #1;
        n_tests++;
        if (buf_wen !== 1'b1 || buf_src !== 2'd1) begin
            n_fail++;
            $display("FAIL full_write: wen=%b src=%0d expected 1,1", buf_wen, buf_src);
        end
        tick();
    endtask

    task automatic test_flush();
        req = 4'hF;
        #1;
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL flush_pre0: grant=%b expected 0100", grant);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL flush_pre1: grant=%b expected 1000", grant);
        end
        tick();
        flush = 1'b1;
        #1;
        n_tests++;
        if (grant !== 4'b0 || buf_wen !== 1'b1 || buf_src !== 2'd3 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_t: grant=%b wen=%b src=%0d fdone=%b expected 0000,1,3,0", grant, buf_wen, buf_src, flush_done);
        end
        tick();
        flush = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0 || buf_wen !== 1'b0 || flush_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_t1: grant=%b wen=%b fdone=%b busy=%b expected 0000,0,0,1", grant, buf_wen, flush_done, busy);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 4'b0 || flush_done !== 1'b1 || write_count !== 16'd14) begin
            n_fail++;
            $display("FAIL flush_t2: grant=%b fdone=%b count=%0d expected 0000,1,14", grant, flush_done, write_count);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 4'b0001 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_t3: grant=%b fdone=%b expected 0001,0", grant, flush_done);
        end
        tick();
        req = 4'h0;
        tick();
        #1;
        n_tests++;
        if (write_count !== 16'd15) begin
            n_fail++;
            $display("FAIL flush_count: count=%0d expected 15", write_count);
        end
    endtask

    task automatic test_wrap();
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        #1;
        n_tests++;
        if (write_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_idle: count=%0d expected 0", write_count);
        end
        req = 4'hF;
        repeat (65535) tick();
        req = 4'h0;
        #1;
        n_tests++;
        if (write_count !== 16'd65534 || buf_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pre: count=%0d wen=%b expected 65534,1", write_count, buf_wen);
        end
        tick();
        #1;
        n_tests++;
        if (write_count !== 16'd65535) begin
            n_fail++;
            $display("FAIL wrap_max: count=%0d expected 65535", write_count);
        end
        req = 4'hF;
        #1;
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant: grant=%b expected 0001", grant);
        end
        tick();
        req = 4'h0;
        tick();
        #1;
        n_tests++;
        if (write_count !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: count=%0d expected 0", write_count);
        end
        req = 4'b0010;
        tick();
        req         = 4'h0;
        count_clear = 1'b1;
        #1;
        n_tests++;
        if (buf_wen !== 1'b1 || buf_src !== 2'd1 || write_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_write: wen=%b src=%0d count=%0d expected 1,1,0", buf_wen, buf_src, write_count);
        end
        tick();
        count_clear = 1'b0;
        #1;
        n_tests++;
        if (write_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_prio: count=%0d expected 0", write_count);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        #1;
        n_tests++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_setup: grant=%b expected 0010", grant);
        end
        tick();
        req = 4'h0;
        #1;
        n_tests++;
        if (buf_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_inflight: wen=%b expected 1", buf_wen);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if (buf_wen !== 1'b0 || write_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: wen=%b count=%0d expected 0,0", buf_wen, write_count);
        end
        tick();
        rstn = 1'b1;
        req  = 4'hF;
        #1;
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_ptr: grant=%b expected 0001", grant);
        end
        tick();
        req = 4'h0;
        tick();
        tick();
    endtask

    initial begin
        rstn        = 1'b1;
        en          = 1'b1;
        req         = '0;
        buf_full    = 1'b0;
        flush       = 1'b0;
        count_clear = 1'b0;
        for (int i = 0; i < NP; i++) begin
            psum_in[i*DW +: DW] = 16'(16'h0100 + i);
        end
        #1 rstn = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_buf_full();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
